// File: rtl/backtrack_fat_unit.sv
// backtrack_fat_unit
// Backtrack bookkeeping for the SAT BCP unit. A small controller scans an
// implication mask one variable per cycle. It either records the mask into
// the force-assign table (FAT) entry of the current decision variable, or
// replays that entry for release and then clears it.
//
// Optional build macro: FAT_OVERWRITE_EN
//   undefined : RECORD ORs the new mask into the existing FAT entry
//   defined   : RECORD clears the FAT entry on the start edge, so the entry
//               ends equal to the newly recorded mask
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a rising edge on backtrack or refresh
// RECORD  | scanning the latched mask, setting FAT[var_q] bit by bit
// RELEASE | scanning the latched FAT entry, reporting released variables
// DONE    | one-cycle completion pulse, then back to IDLE

module backtrack_fat_unit #(
    parameter int VAR_NUM     = 8,
    parameter int VAR_NUM_LOG = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   refresh,
    input  logic                   backtrack,
    input  logic [VAR_NUM-1:0]     implication_reg,
    input  logic [VAR_NUM_LOG-1:0] assign_variable,
    output logic                   busy,
    output logic                   done,
    output logic                   imp_valid,
    output logic                   imp_release,
    output logic [VAR_NUM_LOG-1:0] imp_var,
    input  logic [VAR_NUM_LOG-1:0] fat_rd_addr,
    output logic [VAR_NUM-1:0]     fat_rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECORD  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One extra index bit so the counter never wraps before the last-bit compare.
    localparam logic [VAR_NUM_LOG:0] LP_LAST_IDX = (VAR_NUM_LOG+1)'(VAR_NUM - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_refresh_d;
    logic                   r_backtrack_d;
    logic [VAR_NUM_LOG-1:0] r_var;
    logic [VAR_NUM-1:0]     r_mask;
    logic [VAR_NUM_LOG:0]   r_idx;
    logic [VAR_NUM-1:0]     r_fat [VAR_NUM];

    logic                   r_busy;
    logic                   r_done;
    logic                   r_imp_valid;
    logic                   r_imp_release;
    logic [VAR_NUM_LOG-1:0] r_imp_var;

    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic                   w_imp_valid_nxt;
    logic                   w_imp_release_nxt;
    logic [VAR_NUM_LOG-1:0] w_imp_var_nxt;

    logic                   w_ref_rise;
    logic                   w_bt_rise;
    logic [VAR_NUM_LOG-1:0] w_idx_lo;
    logic                   w_idx_last;
    logic                   w_scan_bit;

    assign w_ref_rise = refresh & ~r_refresh_d;
    assign w_bt_rise  = backtrack & ~r_backtrack_d;
    assign w_idx_lo   = r_idx[VAR_NUM_LOG-1:0];
    assign w_idx_last = (r_idx == LP_LAST_IDX);
    assign w_scan_bit = r_mask[w_idx_lo];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; backtrack beats refresh when both rise together.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_bt_rise) begin
                    w_state_nxt = ST_RELEASE;
                end else if (w_ref_rise) begin
                    w_state_nxt = ST_RECORD;
                end
            end
            ST_RECORD,
            ST_RELEASE: begin
                if (w_idx_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: next values for the registered outputs.
    always_comb begin
        w_busy_nxt        = 1'b0;
        w_done_nxt        = 1'b0;
        w_imp_valid_nxt   = 1'b0;
        w_imp_release_nxt = r_imp_release;
        w_imp_var_nxt     = r_imp_var;
        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = (w_state_nxt != ST_IDLE);
            end
            ST_RECORD: begin
                w_busy_nxt        = 1'b1;
                w_imp_valid_nxt   = w_scan_bit;
                w_imp_release_nxt = 1'b0;
                if (w_scan_bit) begin
                    w_imp_var_nxt = w_idx_lo;
                end
            end
            ST_RELEASE: begin
                w_busy_nxt        = 1'b1;
                w_imp_valid_nxt   = w_scan_bit;
                w_imp_release_nxt = 1'b1;
                if (w_scan_bit) begin
                    w_imp_var_nxt = w_idx_lo;
                end
            end
            ST_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Datapath: edge history, operand latch, scan index, FAT and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_refresh_d   <= 1'b0;
            r_backtrack_d <= 1'b0;
            r_var         <= '0;
            r_mask        <= '0;
            r_idx         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_imp_valid   <= 1'b0;
            r_imp_release <= 1'b0;
            r_imp_var     <= '0;
            for (int i = 0; i < VAR_NUM; i++) begin
                r_fat[i] <= '0;
            end
        end else begin
            // History follows the inputs in every state so a held level never retriggers.
            r_refresh_d   <= refresh;
            r_backtrack_d <= backtrack;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_imp_valid   <= w_imp_valid_nxt;
            r_imp_release <= w_imp_release_nxt;
            r_imp_var     <= w_imp_var_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_state_nxt != ST_IDLE) begin
                        r_var <= assign_variable;
                        r_idx <= '0;
                        if (w_state_nxt == ST_RELEASE) begin
                            r_mask <= r_fat[assign_variable];
                        end else begin
                            r_mask <= implication_reg;
`ifdef FAT_OVERWRITE_EN
                            r_fat[assign_variable] <= '0;
`endif
                        end
                    end
                end
                ST_RECORD: begin
                    if (w_scan_bit) begin
                        r_fat[r_var][w_idx_lo] <= 1'b1;
                    end
                    r_idx <= r_idx + 1'b1;
                end
                ST_RELEASE: begin
                    if (w_idx_last) begin
                        r_fat[r_var] <= '0;
                    end
                    r_idx <= r_idx + 1'b1;
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign imp_valid   = r_imp_valid;
    assign imp_release = r_imp_release;
    assign imp_var     = r_imp_var;
    assign fat_rd_data = r_fat[fat_rd_addr];

endmodule

// File: tb/tb_backtrack_fat_unit.sv
// Self-checking bench for backtrack_fat_unit: directed record/release
// sequences, randomized operations against a table model, same-edge
// priority, ignored mid-operation edges and asynchronous abort.

module tb_backtrack_fat_unit;

    localparam int N = 8;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         refresh;
    logic         backtrack;
    logic [N-1:0] implication_reg;
    logic [L-1:0] assign_variable;
    logic         busy;
    logic         done;
    logic         imp_valid;
    logic         imp_release;
    logic [L-1:0] imp_var;
    logic [L-1:0] fat_rd_addr;
    logic [N-1:0] fat_rd_data;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] model_fat [N];

    backtrack_fat_unit #(.VAR_NUM(N), .VAR_NUM_LOG(L)) dut (
        .clk             (clk),
        .rst             (rst),
        .refresh         (refresh),
        .backtrack       (backtrack),
        .implication_reg (implication_reg),
        .assign_variable (assign_variable),
        .busy            (busy),
        .done            (done),
        .imp_valid       (imp_valid),
        .imp_release     (imp_release),
        .imp_var         (imp_var),
        .fat_rd_addr     (fat_rd_addr),
        .fat_rd_data     (fat_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst             = 1'b0;
        refresh         = 1'b0;
        backtrack       = 1'b0;
        implication_reg = '0;
        assign_variable = '0;
        fat_rd_addr     = '0;
        for (int i = 0; i < N; i++) model_fat[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || imp_valid !== 1'b0 ||
            imp_release !== 1'b0 || imp_var !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b valid=%b rel=%b var=%0d exp all 0",
                     busy, done, imp_valid, imp_release, imp_var);
        end
        for (int a = 0; a < N; a++) begin
            fat_rd_addr = 3'(a);
            #1;
            checks++;
            if (fat_rd_data !== 8'h00) begin
                failures++;
                $display("FAIL reset_fat[%0d] got=%h exp=00", a, fat_rd_data);
            end
        end
    endtask

    // One full operation. is_rel selects RELEASE; both raises refresh too on
    // the start edge; inject raises the other trigger in the middle of the scan.
    task automatic test_operation(input bit is_rel, input bit both, input bit inject,
                                  input logic [L-1:0] v, input logic [N-1:0] m,
                                  input string tag);
        logic [N-1:0] exp_mask;
        exp_mask        = is_rel ? model_fat[v] : m;
        assign_variable = v;
        implication_reg = m;
        refresh         = (!is_rel) || both;
        backtrack       = is_rel;
        @(posedge clk);
        #1;
        assign_variable = 3'($urandom_range(0, N-1));
        implication_reg = 8'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s start_busy got=%b exp=1", tag, busy);
        end
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            if (inject && k == 3) begin
                if (is_rel) refresh = 1'b1;
                else        backtrack = 1'b1;
            end
            checks++;
            if (imp_valid !== exp_mask[k-1] || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL %s scan%0d got valid=%b busy=%b done=%b exp valid=%b busy=1 done=0",
                         tag, k-1, imp_valid, busy, done, exp_mask[k-1]);
            end
            if (exp_mask[k-1]) begin
                checks++;
                if (imp_var !== 3'(k-1) || imp_release !== is_rel) begin
                    failures++;
                    $display("FAIL %s scan_var got var=%0d rel=%b exp var=%0d rel=%b",
                             tag, imp_var, imp_release, k-1, is_rel);
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || imp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulse got done=%b busy=%b valid=%b exp 1 0 0",
                     tag, done, busy, imp_valid);
        end
        if (is_rel) begin
            model_fat[v] = '0;
        end else begin
`ifdef FAT_OVERWRITE_EN
            model_fat[v] = m;
`else
            model_fat[v] = model_fat[v] | m;
`endif
        end
        for (int h = 0; h < 2; h++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || imp_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s no_retrigger got done=%b busy=%b valid=%b exp 0 0 0",
                         tag, done, busy, imp_valid);
            end
        end
        for (int a = 0; a < N; a++) begin
            fat_rd_addr = 3'(a);
            #1;
            checks++;
            if (fat_rd_data !== model_fat[a]) begin
                failures++;
                $display("FAIL %s fat[%0d] got=%h exp=%h", tag, a, fat_rd_data, model_fat[a]);
            end
        end
        refresh   = 1'b0;
        backtrack = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        test_operation(1'b0, 1'b0, 1'b0, 3'd1, 8'b1010_0100, "record1");
        test_operation(1'b0, 1'b0, 1'b0, 3'd3, 8'b0101_0000, "record2");
        test_operation(1'b1, 1'b0, 1'b0, 3'd1, 8'h00,        "release1");
        test_operation(1'b0, 1'b0, 1'b0, 3'd3, 8'b0000_0001, "accumulate");
        test_operation(1'b0, 1'b0, 1'b0, 3'd5, 8'h00,        "zero_mask");
        test_operation(1'b0, 1'b0, 1'b0, 3'd7, 8'hFF,        "full_mask");
    endtask

    task automatic test_priority();
        test_operation(1'b0, 1'b0, 1'b0, 3'd6, 8'b1001_0010, "prio_setup");
        test_operation(1'b1, 1'b1, 1'b0, 3'd6, 8'h3C,        "same_edge");
        test_operation(1'b0, 1'b0, 1'b0, 3'd2, 8'b0110_0001, "prio_setup2");
        test_operation(1'b1, 1'b0, 1'b1, 3'd2, 8'h00,        "refresh_in_release");
        test_operation(1'b0, 1'b0, 1'b1, 3'd4, 8'b0001_1000, "backtrack_in_record");
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            test_operation(($urandom_range(0, 2) == 0), 1'b0, ($urandom_range(0, 3) == 0),
                           3'($urandom_range(0, N-1)), 8'($urandom), "random");
        end
    endtask

    task automatic test_abort();
        test_operation(1'b0, 1'b0, 1'b0, 3'd0, 8'hC3, "abort_setup");
        assign_variable = 3'd2;
        implication_reg = 8'hFF;
        refresh         = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || imp_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs got busy=%b valid=%b done=%b exp 0 0 0",
                     busy, imp_valid, done);
        end
        for (int a = 0; a < N; a++) begin
            fat_rd_addr = 3'(a);
            #1;
            checks++;
            if (fat_rd_data !== 8'h00) begin
                failures++;
                $display("FAIL abort_fat[%0d] got=%h exp=00", a, fat_rd_data);
            end
        end
        refresh = 1'b0;
        for (int i = 0; i < N; i++) model_fat[i] = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_operation(1'b0, 1'b0, 1'b0, 3'd2, 8'h81, "after_abort");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_priority();
        test_random();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
